// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each transaction is IDLE -> ACCESS -> RESP; misaligned or out-of-range addresses answer with an error.
module dmem_arbiter #(
  parameter int WORD  = 64,
  parameter int DEPTH = 32
) (
  input  logic            im_clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [WORD-1:0] m0_addr,
  input  logic [WORD-1:0] m0_wdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [WORD-1:0] m1_addr,
  input  logic [WORD-1:0] m1_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [WORD-1:0] m0_rdata,
  output logic            m0_err,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [WORD-1:0] m1_rdata,
  output logic            m1_err,
  output logic            mem_read,
  output logic            mem_write,
  output logic [WORD-1:0] mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [WORD-1:0] ADDR_LIMIT = WORD'(DEPTH * 8);

  state_t          r_state;
  logic            r_id;
  logic            r_we;
  logic            r_err;
  logic            r_last;
  logic [1:0]      r_gnt;
  logic [1:0]      r_rvalid;
  logic [1:0]      r_err_out;
  logic            r_mem_read;
  logic            r_mem_write;
  logic [WORD-1:0] r_mem_addr;
  logic [WORD-1:0] r_mem_wdata;
  logic [WORD-1:0] r_rdata0;
  logic [WORD-1:0] r_rdata1;
  logic            r_busy;

  logic            w_any;
  logic            w_win;
  logic            w_we_sel;
  logic [WORD-1:0] w_addr_sel;
  logic [WORD-1:0] w_wdata_sel;
  logic            w_addr_bad;
  logic            w_pass0;
  logic            w_pass1;

  // Round-robin winner selection and address legality check for the candidate request
  always_comb begin
    w_any = m0_req | m1_req;
    if (m0_req && m1_req) begin
      w_win = ~r_last;
    end else if (m1_req) begin
      w_win = 1'b1;
    end else begin
      w_win = 1'b0;
    end
    w_we_sel    = w_win ? m1_we    : m0_we;
    w_addr_sel  = w_win ? m1_addr  : m0_addr;
    w_wdata_sel = w_win ? m1_wdata : m0_wdata;
    w_addr_bad  = (w_addr_sel[2:0] != 3'd0) || (w_addr_sel >= ADDR_LIMIT);
  end

  // Transaction FSM with all requester- and memory-side outputs registered
  always_ff @(posedge im_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_last      <= 1'b1;
      r_gnt       <= 2'b00;
      r_rvalid    <= 2'b00;
      r_err_out   <= 2'b00;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt       <= 2'b00;
      r_rvalid    <= 2'b00;
      r_err_out   <= 2'b00;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state        <= ACCESS;
            r_busy         <= 1'b1;
            r_id           <= w_win;
            r_we           <= w_we_sel;
            r_err          <= w_addr_bad;
            r_gnt[w_win]   <= 1'b1;
            r_mem_addr     <= w_addr_sel;
            r_mem_wdata    <= w_wdata_sel;
            r_mem_read     <= ~w_addr_bad & ~w_we_sel;
            r_mem_write    <= ~w_addr_bad & w_we_sel;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        ACCESS: begin
          r_state             <= RESP;
          r_rvalid[r_id]      <= 1'b1;
          r_err_out[r_id]     <= r_err;
          // An error response must present zero data alongside rvalid
          if (r_err) begin
            if (r_id) begin
              r_rdata1 <= '0;
            end else begin
              r_rdata0 <= '0;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_last  <= r_id;
          if (!r_we && !r_err) begin
            if (r_id) begin
              r_rdata1 <= mem_rdata;
            end else begin
              r_rdata0 <= mem_rdata;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Load data is forwarded during RESP only; the holding register keeps it afterwards
  assign w_pass0 = (r_state == RESP) && !r_we && !r_err && !r_id;
  assign w_pass1 = (r_state == RESP) && !r_we && !r_err && r_id;

  assign m0_gnt    = r_gnt[0];
  assign m1_gnt    = r_gnt[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_err    = r_err_out[0];
  assign m1_err    = r_err_out[1];
  assign m0_rdata  = w_pass0 ? mem_rdata : r_rdata0;
  assign m1_rdata  = w_pass1 ? mem_rdata : r_rdata1;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grant/memory/response events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_dmem_arbiter;

  localparam int K_GNT = 0;
  localparam int K_RD  = 1;
  localparam int K_WR  = 2;
  localparam int K_RV  = 3;

  typedef struct {
    int          kind;
    int          port;
    int          cyc;
    logic [63:0] data;
    logic [63:0] wdata;
    logic        err;
  } ev_t;

  logic        im_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [63:0] m0_addr = 64'd0, m0_wdata = 64'd0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [63:0] m1_addr = 64'd0, m1_wdata = 64'd0;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [63:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  logic [63:0] mem [0:31];
  logic [63:0] rd_q = 64'd0;
  logic        rd_v = 1'b0;
  logic        preload = 1'b1;

  ev_t         q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [63:0] exp_last [2];

  dmem_arbiter #(.WORD(64), .DEPTH(32)) dut (
    .im_clk(im_clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 im_clk = ~im_clk;

  always @(posedge im_clk) cyc <= cyc + 1;

  // Registered-read memory model; read data is high-Z except in the cycle after a read
  always @(posedge im_clk) begin
    if (preload) begin
      mem[2] <= 64'hDEAD;
      mem[3] <= 64'd0;
    end else if (mem_write) begin
      mem[mem_addr[7:3]] <= mem_wdata;
    end
    if (mem_read) begin
      rd_q <= mem[mem_addr[7:3]];
      rd_v <= 1'b1;
    end else begin
      rd_v <= 1'b0;
    end
  end
  assign mem_rdata = rd_v ? rd_q : {64{1'bz}};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int p, input int c, input logic [63:0] d,
                      input logic [63:0] wd, input logic e);
    ev_t x;
    x.kind = k; x.port = p; x.cyc = c; x.data = d; x.wdata = wd; x.err = e;
    q.push_back(x);
  endtask

  task automatic observe(input int k, input int p, input logic [63:0] d,
                         input logic [63:0] wd, input logic e);
    ev_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind=%0d port=%0d at cycle %0d data=%h", k, p, cyc, d);
    end else begin
      x = q.pop_front();
      if (x.kind != k || x.port != p || x.cyc != cyc || x.data !== d ||
          x.wdata !== wd || x.err !== e) begin
        errors++;
        $display("FAIL event: got kind=%0d port=%0d cyc=%0d data=%h wdata=%h err=%b; expected kind=%0d port=%0d cyc=%0d data=%h wdata=%h err=%b",
                 k, p, cyc, d, wd, e, x.kind, x.port, x.cyc, x.data, x.wdata, x.err);
      end
    end
  endtask

  // Monitor: every output pulse must match the head of the expected-event queue
  always @(negedge im_clk) begin
    if (m0_gnt)    observe(K_GNT, 0, 64'd0, 64'd0, 1'b0);
    if (m1_gnt)    observe(K_GNT, 1, 64'd0, 64'd0, 1'b0);
    if (mem_read)  observe(K_RD, 0, mem_addr, 64'd0, 1'b0);
    if (mem_write) observe(K_WR, 0, mem_addr, mem_wdata, 1'b0);
    if (m0_rvalid) observe(K_RV, 0, m0_rdata, 64'd0, m0_err);
    if (m1_rvalid) observe(K_RV, 1, m1_rdata, 64'd0, m1_err);
  end

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [63:0] addr, input logic [63:0] wd);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // Single transaction; called at posedge+1 with the DUT idle, returns 3 cycles later
  task automatic issue(input int p, input logic we, input logic [63:0] addr,
                       input logic [63:0] wd, input logic [63:0] rd, input logic bad,
                       input logic mutate);
    int c;
    logic [63:0] rv;
    c = cyc;
    push(K_GNT, 0 + p, c + 1, 64'd0, 64'd0, 1'b0);
    if (!bad) begin
      if (we) push(K_WR, 0, c + 1, addr, wd, 1'b0);
      else    push(K_RD, 0, c + 1, addr, 64'd0, 1'b0);
    end
    rv = bad ? 64'd0 : (we ? exp_last[p] : rd);
    push(K_RV, p, c + 2, rv, 64'd0, bad);
    exp_last[p] = rv;
    drive(p, 1'b1, we, addr, wd);
    @(posedge im_clk); #1;
    if (mutate) drive(p, 1'b0, 1'b1, 64'h18, 64'hBAD);
    else        drive(p, 1'b0, we, addr, wd);
    @(posedge im_clk); @(posedge im_clk); #1;
  endtask

  // Both ports load continuously; grants must alternate starting with port 0
  task automatic both(input int n);
    int c;
    int p;
    c = cyc;
    for (int i = 0; i < n; i++) begin
      p = i % 2;
      push(K_GNT, p, c + 1 + 3 * i, 64'd0, 64'd0, 1'b0);
      push(K_RD, 0, c + 1 + 3 * i, (p == 0) ? 64'h10 : 64'h18, 64'd0, 1'b0);
      push(K_RV, p, c + 2 + 3 * i, (p == 0) ? 64'hDEAD : 64'h55, 64'd0, 1'b0);
    end
    exp_last[0] = 64'hDEAD;
    exp_last[1] = 64'h55;
    drive(0, 1'b1, 1'b0, 64'h10, 64'd0);
    drive(1, 1'b1, 1'b0, 64'h18, 64'd0);
    repeat (3 * (n - 1) + 1) @(posedge im_clk);
    #1;
    drive(0, 1'b0, 1'b0, 64'h10, 64'd0);
    drive(1, 1'b0, 1'b0, 64'h18, 64'd0);
    @(posedge im_clk); @(posedge im_clk); #1;
  endtask

  initial begin
    exp_last[0] = 64'd0;
    exp_last[1] = 64'd0;
    repeat (3) @(posedge im_clk);
    #1;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_strobes", {60'd0, mem_read, mem_write, m0_gnt, m1_gnt}, 64'd0);
    chk("reset_rvalid_err", {60'd0, m0_rvalid, m1_rvalid, m0_err, m1_err}, 64'd0);
    chk("reset_mem_addr", mem_addr, 64'd0);
    chk("reset_mem_wdata", mem_wdata, 64'd0);
    chk("reset_m0_rdata", m0_rdata, 64'd0);
    chk("reset_m1_rdata", m1_rdata, 64'd0);
    preload = 1'b0;
    rst_n   = 1'b1;
    @(posedge im_clk); #1;

    issue(0, 1'b0, 64'h10, 64'd0, 64'hDEAD, 1'b0, 1'b0);
    issue(1, 1'b1, 64'h18, 64'h55, 64'd0, 1'b0, 1'b0);
    issue(1, 1'b0, 64'h18, 64'd0, 64'h55, 1'b0, 1'b0);
    chk("m1_rdata_hold", m1_rdata, 64'h55);
    issue(0, 1'b0, 64'h0C, 64'd0, 64'd0, 1'b1, 1'b0);
    issue(0, 1'b0, 64'h100, 64'd0, 64'd0, 1'b1, 1'b0);
    issue(0, 1'b0, 64'h10, 64'd0, 64'hDEAD, 1'b0, 1'b1);
    chk("m0_rdata_hold", m0_rdata, 64'hDEAD);

    // Reset asserted in the ACCESS cycle of a load
    drive(0, 1'b1, 1'b0, 64'h10, 64'd0);
    @(posedge im_clk); #1;
    chk("access_mem_read", {63'd0, mem_read}, 64'd1);
    chk("access_busy", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_read", {63'd0, mem_read}, 64'd0);
    chk("abort_mem_write", {63'd0, mem_write}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    drive(0, 1'b0, 1'b0, 64'h10, 64'd0);
    exp_last[0] = 64'd0;
    exp_last[1] = 64'd0;
    repeat (2) @(posedge im_clk);
    #1;
    chk("abort_m0_rdata", m0_rdata, 64'd0);
    rst_n = 1'b1;
    @(posedge im_clk); #1;
    both(4);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge im_clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
